// File: rtl/andla_ldma_seq_if.sv
// Beat request channel from the load-DMA sequencer to the downstream data mover.
// The master presents addresses with valid/last. The slave accepts a beat with ready.
interface andla_ldma_seq_if #(
  parameter int unsigned EXRAM_ADDR_W = 32,
  parameter int unsigned SHRAM_ADDR_W = 16
);
  logic                    valid;
  logic                    ready;
  logic [EXRAM_ADDR_W-1:0] exram_addr;
  logic [SHRAM_ADDR_W-1:0] shram_addr;
  logic                    last;

  modport master (
    output valid,
    output exram_addr,
    output shram_addr,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  exram_addr,
    input  shram_addr,
    input  last,
    output ready
  );
endinterface

// File: rtl/andla_ldma_seq.sv
// Load-DMA address sequencer: walks a w/h/n strided exram region and issues one beat
// per element toward consecutive shram words. Addresses are built by adders only.
module andla_ldma_seq #(
  parameter int unsigned EXRAM_ADDR_W = 32,
  parameter int unsigned SHRAM_ADDR_W = 16,
  parameter int unsigned DIM_W        = 16,
  parameter int unsigned STRIDE_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [EXRAM_ADDR_W-1:0] cfg_exram_addr_i,
  input  logic [SHRAM_ADDR_W-1:0] cfg_shram_addr_i,
  input  logic [DIM_W-1:0]        cfg_w_i,
  input  logic [DIM_W-1:0]        cfg_h_i,
  input  logic [DIM_W-1:0]        cfg_n_i,
  input  logic [STRIDE_W-1:0]     cfg_stride_w_i,
  input  logic [STRIDE_W-1:0]     cfg_stride_h_i,
  input  logic [STRIDE_W-1:0]     cfg_stride_n_i,
  andla_ldma_seq_if.master        req,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    except_trigger_o
);

  localparam int unsigned CntW = 3 * DIM_W;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [DIM_W-1:0]        w_q, h_q, n_q;
  logic [DIM_W-1:0]        iw_q, ih_q, in_q;
  logic [EXRAM_ADDR_W-1:0] stride_w_q, stride_h_q, stride_n_q;
  logic [EXRAM_ADDR_W-1:0] addr_q, row_q, plane_q;
  logic [SHRAM_ADDR_W-1:0] shram_base_q, shram_q;
  logic [CntW-1:0]         beat_cnt_q;
  logic                    valid_q, last_q, busy_q, done_q, exc_q;

  logic [DIM_W-1:0]        iw_d, ih_d, in_d;
  logic [EXRAM_ADDR_W-1:0] addr_d, row_d, plane_d;
  logic                    last_d, iw_wrap, ih_wrap, cfg_zero, cfg_single;

  // Position and address of the beat following the current one.
  always_comb begin
    iw_d    = iw_q;
    ih_d    = ih_q;
    in_d    = in_q;
    addr_d  = addr_q;
    row_d   = row_q;
    plane_d = plane_q;
    iw_wrap = (iw_q == (w_q - DIM_W'(1)));
    ih_wrap = (ih_q == (h_q - DIM_W'(1)));
    if (!iw_wrap) begin
      iw_d   = iw_q + DIM_W'(1);
      addr_d = addr_q + stride_w_q;
    end else if (!ih_wrap) begin
      iw_d   = '0;
      ih_d   = ih_q + DIM_W'(1);
      row_d  = row_q + stride_h_q;
      addr_d = row_d;
    end else begin
      iw_d    = '0;
      ih_d    = '0;
      in_d    = in_q + DIM_W'(1);
      plane_d = plane_q + stride_n_q;
      row_d   = plane_d;
      addr_d  = plane_d;
    end
    last_d = (iw_d == (w_q - DIM_W'(1))) && (ih_d == (h_q - DIM_W'(1))) &&
             (in_d == (n_q - DIM_W'(1)));
    cfg_zero   = (cfg_w_i == '0) || (cfg_h_i == '0) || (cfg_n_i == '0);
    cfg_single = (cfg_w_i == DIM_W'(1)) && (cfg_h_i == DIM_W'(1)) && (cfg_n_i == DIM_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      w_q          <= '0;
      h_q          <= '0;
      n_q          <= '0;
      iw_q         <= '0;
      ih_q         <= '0;
      in_q         <= '0;
      stride_w_q   <= '0;
      stride_h_q   <= '0;
      stride_n_q   <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      shram_base_q <= '0;
      shram_q      <= '0;
      beat_cnt_q   <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Any start outside IDLE (including the DONE cycle) is flagged and otherwise dropped.
      exc_q  <= start_i && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (start_i) begin
            w_q          <= cfg_w_i;
            h_q          <= cfg_h_i;
            n_q          <= cfg_n_i;
            stride_w_q   <= EXRAM_ADDR_W'(cfg_stride_w_i);
            stride_h_q   <= EXRAM_ADDR_W'(cfg_stride_h_i);
            stride_n_q   <= EXRAM_ADDR_W'(cfg_stride_n_i);
            iw_q         <= '0;
            ih_q         <= '0;
            in_q         <= '0;
            addr_q       <= cfg_exram_addr_i;
            row_q        <= cfg_exram_addr_i;
            plane_q      <= cfg_exram_addr_i;
            shram_base_q <= cfg_shram_addr_i;
            shram_q      <= cfg_shram_addr_i;
            beat_cnt_q   <= '0;
            busy_q       <= 1'b1;
            if (cfg_zero) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              valid_q <= 1'b1;
              last_q  <= cfg_single;
            end
          end
        end
        StRun: begin
          if (valid_q && req.ready) begin
            if (last_q) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              iw_q       <= iw_d;
              ih_q       <= ih_d;
              in_q       <= in_d;
              addr_q     <= addr_d;
              row_q      <= row_d;
              plane_q    <= plane_d;
              beat_cnt_q <= beat_cnt_q + CntW'(1);
              shram_q    <= shram_base_q + SHRAM_ADDR_W'(beat_cnt_q + CntW'(1));
              last_q     <= last_d;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req.valid        = valid_q;
  assign req.exram_addr   = addr_q;
  assign req.shram_addr   = shram_q;
  assign req.last         = last_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign except_trigger_o = exc_q;

endmodule

// File: tb/tb_andla_ldma_seq.sv
// Bench for andla_ldma_seq: a queue-based beat model built with plain multiplies,
// checked against the DUT every cycle, plus literal checks on captured sequences.
module tb_andla_ldma_seq;

  typedef struct packed {
    logic [31:0] ex;
    logic [15:0] sh;
  } beat_t;

  typedef struct packed {
    logic [31:0] ex;
    logic [15:0] sh;
    logic        last;
  } cap_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] cfg_ex = '0;
  logic [15:0] cfg_sh = '0;
  logic [15:0] cfg_w = '0, cfg_h = '0, cfg_n = '0;
  logic [31:0] cfg_sw = '0, cfg_shs = '0, cfg_sn = '0;
  logic        rdy = 1'b0;
  logic        busy, done, exc;
  int          rdy_mode = 0;

  int vectors = 0;
  int miscompares = 0;

  andla_ldma_seq_if #(.EXRAM_ADDR_W(32), .SHRAM_ADDR_W(16)) req_if ();
  assign req_if.ready = rdy;

  andla_ldma_seq #(
    .EXRAM_ADDR_W(32),
    .SHRAM_ADDR_W(16),
    .DIM_W       (16),
    .STRIDE_W    (32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .cfg_exram_addr_i(cfg_ex),
    .cfg_shram_addr_i(cfg_sh),
    .cfg_w_i         (cfg_w),
    .cfg_h_i         (cfg_h),
    .cfg_n_i         (cfg_n),
    .cfg_stride_w_i  (cfg_sw),
    .cfg_stride_h_i  (cfg_shs),
    .cfg_stride_n_i  (cfg_sn),
    .req             (req_if),
    .busy_o          (busy),
    .done_o          (done),
    .except_trigger_o(exc)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat list straight from the address formula.
  task automatic gen(input logic [31:0] base, input logic [15:0] shb, input int unsigned w,
                     input int unsigned h, input int unsigned n, input longint unsigned sw,
                     input longint unsigned sh, input longint unsigned sn,
                     output beat_t q[$]);
    longint unsigned acc;
    int unsigned k;
    beat_t b;
    q = {};
    k = 0;
    for (int unsigned i_n = 0; i_n < n; i_n++)
      for (int unsigned i_h = 0; i_h < h; i_h++)
        for (int unsigned i_w = 0; i_w < w; i_w++) begin
          acc  = longint'(base) + i_w * sw + i_h * sh + i_n * sn;
          b.ex = acc[31:0];
          b.sh = shb + k[15:0];
          q.push_back(b);
          k++;
        end
  endtask

  // Model state: pending beats, busy/done/except expectations.
  beat_t mq[$];
  logic  m_idle = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_exc = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq = {};
      m_idle = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_exc  = 1'b0;
    end else begin
      logic was_idle, prev_done;
      was_idle  = m_idle;
      prev_done = m_done;
      m_done    = 1'b0;
      m_exc     = start && !was_idle;
      if (mq.size() > 0 && rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_done = 1'b1;
      end
      if (prev_done) begin
        m_idle = 1'b1;
        m_busy = 1'b0;
      end
      if (start && was_idle) begin
        gen(cfg_ex, cfg_sh, cfg_w, cfg_h, cfg_n, cfg_sw, cfg_shs, cfg_sn, mq);
        m_idle = 1'b0;
        m_busy = 1'b1;
        if (mq.size() == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", req_if.valid, mq.size() > 0);
    chk("last", req_if.last, mq.size() == 1);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("except", exc, m_exc);
    if (mq.size() > 0) begin
      chk("exram", req_if.exram_addr, mq[0].ex);
      chk("shram", req_if.shram_addr, mq[0].sh);
    end
  end

  // Handshakes as the DUT actually produced them.
  cap_t cap[$];
  always @(posedge clk) begin
    if (rst_n && req_if.valid && req_if.ready) begin
      cap_t c;
      c.ex   = req_if.exram_addr;
      c.sh   = req_if.shram_addr;
      c.last = req_if.last;
      cap.push_back(c);
    end
  end

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = ~rdy;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic do_start(input logic [31:0] ex, input logic [15:0] sh, input logic [15:0] w,
                          input logic [15:0] h, input logic [15:0] n, input logic [31:0] sw,
                          input logic [31:0] shs, input logic [31:0] sn);
    @(negedge clk);
    cap = {};
    cfg_ex = ex; cfg_sh = sh; cfg_w = w; cfg_h = h; cfg_n = n;
    cfg_sw = sw; cfg_shs = shs; cfg_sn = sn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Later cfg changes must not leak into the running command.
    cfg_ex = $urandom; cfg_sh = 16'($urandom); cfg_w = 16'($urandom);
    cfg_h = 16'($urandom); cfg_n = 16'($urandom);
    cfg_sw = $urandom; cfg_shs = $urandom; cfg_sn = $urandom;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({name, "_done_seen"}, seen, 1'b1);
    @(negedge clk);
  endtask

  task automatic chk_seq4(input string name, input logic [31:0] ex[4], input logic [15:0] sh[4]);
    chk({name, "_beats"}, cap.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap.size()) begin
        chk({name, "_ex"}, cap[i].ex, ex[i]);
        chk({name, "_sh"}, cap[i].sh, sh[i]);
        chk({name, "_last"}, cap[i].last, i == 3);
      end
    end
  endtask

  initial begin
    beat_t pin[$];
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", req_if.valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_exram", req_if.exram_addr, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Pin the model against hand-computed values.
    gen(32'hFFFF_FFF8, 16'hFFFE, 4, 1, 1, 4, 0, 0, pin);
    chk("model_wrap_ex2", pin[2].ex, 32'h0);
    chk("model_wrap_sh3", pin[3].sh, 16'h0001);
    gen(32'h1000, 16'h0, 2, 2, 1, 4, 32'h100, 0, pin);
    chk("model_basic_ex3", pin[3].ex, 32'h1104);

    rdy_mode = 0;
    do_start(32'h1000, 16'h0, 2, 2, 1, 4, 32'h100, 32'h0);
    wait_done("basic", 20);
    chk_seq4("basic", '{32'h1000, 32'h1004, 32'h1100, 32'h1104}, '{16'd0, 16'd1, 16'd2, 16'd3});

    rdy_mode = 1;
    do_start(32'h1000, 16'h0, 2, 2, 1, 4, 32'h100, 32'h0);
    wait_done("bp", 30);
    chk_seq4("bp", '{32'h1000, 32'h1004, 32'h1100, 32'h1104}, '{16'd0, 16'd1, 16'd2, 16'd3});

    rdy_mode = 0;
    do_start(32'h1000, 16'h0, 2, 0, 1, 4, 32'h100, 32'h0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b1);
    chk("zero_valid", req_if.valid, 1'b0);
    @(negedge clk);
    chk("zero_busy_after", busy, 1'b0);

    do_start(32'h1000, 16'h0, 2, 2, 1, 4, 32'h100, 32'h0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("illegal_exc", exc, 1'b1);
    wait_done("illegal", 20);
    chk_seq4("illegal", '{32'h1000, 32'h1004, 32'h1100, 32'h1104},
             '{16'd0, 16'd1, 16'd2, 16'd3});

    do_start(32'hFFFF_FFF8, 16'hFFFE, 4, 1, 1, 4, 32'h0, 32'h0);
    wait_done("wrap", 20);
    chk_seq4("wrap", '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4},
             '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});

    do_start(32'h4000, 16'h10, 8, 1, 1, 4, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", req_if.valid, 1'b0);
    chk("mid_rst_last", req_if.last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_exram", req_if.exram_addr, 32'h0);
    chk("mid_rst_shram", req_if.shram_addr, 16'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_start(32'h2000, 16'h40, 4, 1, 1, 8, 32'h0, 32'h0);
    wait_done("after_rst", 20);
    chk_seq4("after_rst", '{32'h2000, 32'h2008, 32'h2010, 32'h2018},
             '{16'h40, 16'h41, 16'h42, 16'h43});

    rdy_mode = 2;
    do_start(32'h8000_0000, 16'h100, 3, 2, 2, 8, 32'h40, 32'h1000);
    wait_done("cube", 100);
    chk("cube_beats", cap.size(), 12);

    rdy_mode = 0;
    do_start(32'h55, 16'h7, 1, 1, 1, 4, 32'h4, 32'h4);
    wait_done("single", 10);
    chk("single_beats", cap.size(), 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
